// File: rtl/bnn_mac_unit.sv
// Binary multiply-accumulate: popcount of (window op weights) summed over N_CH beats.
// Define BNN_XNOR_EN for XNOR-popcount (+/-1 networks); default is AND-popcount.
module bnn_mac_unit #(
  parameter int unsigned N_TAPS = 9,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned ACC_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wgt_we,
  input  logic [N_TAPS-1:0] wgt_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_TAPS-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(N_CH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N_CH);

  // Even taps set, odd taps clear.
  function automatic logic [N_TAPS-1:0] alt_pattern();
    logic [N_TAPS-1:0] w;
    for (int i = 0; i < N_TAPS; i++) begin
      w[i] = ((i % 2) == 0);
    end
    return w;
  endfunction

  localparam logic [N_TAPS-1:0] DefaultWgt = alt_pattern();

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e            state_q;
  logic [N_TAPS-1:0] wgt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CntW-1:0]   ch_cnt_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [N_TAPS-1:0] term;
  logic [ACC_W-1:0]  pop;
  logic [ACC_W-1:0]  acc_sum;
  logic [CntW-1:0]   ch_cnt_inc;
  logic              beat;

  always_comb begin
`ifdef BNN_XNOR_EN
    term = ~(in_data ^ wgt_q);
`else
    term = in_data & wgt_q;
`endif
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      pop = pop + ACC_W'(term[i]);
    end
  end

  assign beat       = in_valid & in_ready_q;
  assign acc_sum    = acc_q + pop;
  assign ch_cnt_inc = ch_cnt_q + CntW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wgt_q       <= DefaultWgt;
      acc_q       <= '0;
      ch_cnt_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // The beat sampled this cycle still sees the old weights.
          if (wgt_we) begin
            wgt_q <= wgt_in;
          end
          if (beat) begin
            acc_q    <= pop;
            ch_cnt_q <= CntW'(1);
            busy_q   <= 1'b1;
            if (N_CH == 1) begin
              state_q     <= StHold;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (beat) begin
            acc_q    <= acc_sum;
            ch_cnt_q <= ch_cnt_inc;
            if (ch_cnt_inc == LastCnt) begin
              state_q     <= StHold;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            ch_cnt_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          acc_q       <= '0;
          ch_cnt_q    <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bnn_mac_unit.sv
// Scoreboard bench for bnn_mac_unit: a behavioural model queues expected sums,
// the monitor pops and compares them on each output handshake.
module tb_bnn_mac_unit;

  localparam int unsigned NT = 9;
  localparam int unsigned NC = 4;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wgt_we;
  logic [NT-1:0] wgt_in;
  logic          in_valid;
  logic          in_ready;
  logic [NT-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          busy;

  logic          one_valid;
  logic          one_ready;
  logic [NT-1:0] one_data;
  logic          one_ovalid;
  logic [3:0]    one_sum;
  logic          one_busy;

  always #5 clk = ~clk;

  bnn_mac_unit #(.N_TAPS(NT), .N_CH(NC), .ACC_W(AW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wgt_we    (wgt_we),
    .wgt_in    (wgt_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  bnn_mac_unit #(.N_TAPS(NT), .N_CH(1), .ACC_W(4)) u_one (
    .clk       (clk),
    .rst_n     (rst_n),
    .wgt_we    (1'b0),
    .wgt_in    ('0),
    .in_valid  (one_valid),
    .in_ready  (one_ready),
    .in_data   (one_data),
    .out_valid (one_ovalid),
    .out_ready (1'b1),
    .out_sum   (one_sum),
    .busy      (one_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int last_sum = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model of the unit's behaviour.
  typedef enum int {MIdle, MAccum, MHold} mst_e;
  mst_e          m_st;
  logic [NT-1:0] m_w;
  int            m_acc;
  int            m_cnt;
  int            exp_q[$];

  function automatic int ref_pop(input logic [NT-1:0] d, input logic [NT-1:0] w);
    int p = 0;
    for (int i = 0; i < NT; i++) begin
`ifdef BNN_XNOR_EN
      p += int'(~(d[i] ^ w[i]));
`else
      p += int'(d[i] & w[i]);
`endif
    end
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st  <= MIdle;
      m_w   <= 9'h155;
      m_acc <= 0;
      m_cnt <= 0;
      exp_q.delete();
    end else begin
      case (m_st)
        MIdle: begin
          if (wgt_we) m_w <= wgt_in;
          if (in_valid) begin
            m_acc <= ref_pop(in_data, m_w);
            m_cnt <= 1;
            m_st  <= MAccum;
          end
        end
        MAccum: begin
          if (in_valid) begin
            m_acc <= m_acc + ref_pop(in_data, m_w);
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == NC) begin
              exp_q.push_back(m_acc + ref_pop(in_data, m_w));
              m_st <= MHold;
            end
          end
        end
        default: begin
          if (out_ready) begin
            m_st  <= MIdle;
            m_acc <= 0;
            m_cnt <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("in_ready", in_ready, m_st != MHold);
      check_eq("out_valid", out_valid, m_st == MHold);
      check_eq("busy", busy, m_st != MIdle);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("out_unexpected", out_valid, 0);
        end else begin
          check_eq("out_sum", out_sum, exp_q.pop_front());
          last_sum = int'(out_sum);
          n_out++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [NT-1:0] d);
    logic ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    if (!ok) check_eq("beat_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic write_w(input logic [NT-1:0] w);
    wgt_we = 1'b1;
    wgt_in = w;
    tick();
    wgt_we = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 64; k++) begin
      if (!out_valid && m_st == MIdle) break;
      tick();
    end
    check_eq("drain", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    wgt_we    = 1'b0;
    wgt_in    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    one_valid = 1'b0;
    one_data  = '0;
    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_sum", out_sum, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_one_valid", one_ovalid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // N_CH=1 instance: one beat of all ones against default weights.
    one_valid = 1'b1;
    one_data  = 9'h1FF;
    @(negedge clk);
    check_eq("one_ready", one_ready, 1);
    tick();
    one_valid = 1'b0;
    check_eq("one_valid", one_ovalid, 1);
    check_eq("one_sum", one_sum, 5);
    check_eq("one_hold_ready", one_ready, 0);
    check_eq("one_busy", one_busy, 1);
    tick();
    check_eq("one_released", one_ovalid, 0);
    check_eq("one_ready_back", one_ready, 1);

    // Back-to-back window, output one cycle after the last beat.
    repeat (4) send_beat(9'h1FF);
    check_eq("lat_valid", out_valid, 1);
    check_eq("sum_ones", out_sum, 20);
    tick();
    check_eq("idle_ready", in_ready, 1);
    check_eq("idle_busy", busy, 0);

    // Backpressure with in_valid held high.
    out_ready = 1'b0;
    repeat (4) send_beat(9'h1FF);
    in_valid = 1'b1;
    in_data  = 9'h1FF;
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_ready", in_ready, 0);
      check_eq("bp_stable", out_sum, 20);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_eq("bp_release_ready", in_ready, 1);
    check_eq("bp_release_busy", busy, 0);
    tick();
    in_valid = 1'b0;
    check_eq("bp_restart_busy", busy, 1);
    repeat (3) send_beat(9'h1FF);
    drain();
    check_eq("bp_second_sum", last_sum, 20);

    // Weight write in IDLE honoured, write during ACCUM ignored.
    write_w(9'h1FF);
    send_beat(9'h0FF);
    send_beat(9'h1FF);
    write_w(9'h000);
    send_beat(9'h000);
    send_beat(9'h001);
    drain();
    check_eq("sum_wgt", last_sum, 18);

    // Gapped input: one output only.
    write_w(9'h155);
    base = n_out;
    for (int i = 0; i < 4; i++) begin
      send_beat(9'h155);
      repeat (i) tick();
    end
    drain();
`ifdef BNN_XNOR_EN
    check_eq("sum_gapped", last_sum, 36);
`else
    check_eq("sum_gapped", last_sum, 20);
`endif
    check_eq("gapped_count", n_out - base, 1);

    repeat (4) send_beat(9'h0AA);
    drain();
    check_eq("sum_0aa", last_sum, 0);

    // Weight write coinciding with the first beat: that beat keeps old weights.
    wgt_we = 1'b1;
    wgt_in = 9'h000;
    send_beat(9'h1FF);
    wgt_we = 1'b0;
    repeat (3) send_beat(9'h1FF);
    drain();
    check_eq("sum_wr_first", last_sum, 5);

    // Reset mid-window discards the partial sum and restores default weights.
    send_beat(9'h1FF);
    send_beat(9'h1FF);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_sum", out_sum, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    repeat (4) send_beat(9'h1FF);
    drain();
    check_eq("sum_after_rst", last_sum, 20);

    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("out_count", n_out, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
